manage_hp_param: RTL and testbench

//  Parametrised two-player HP manager for the factorization duel, fed by the win/lose judge.
//  - Holds both players' HP.
//  - Subtracts difficulty-weighted damage on each judged round; the difficulty is taken from the DB word.
//  - Runs the game round through a start/play/over state machine and reports the winner.
//  - Sits between win_lose/DB and the display/state controller.
//  - Adds over the previous generation: saturating arithmetic, a draw mode, restart, and a game-over handshake.

---
 rtl/manage_hp_param.sv | 131 +++++++++++++
 tb/tb_manage_hp_param.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/manage_hp_param.sv
// manage_hp_param
//   Two-player HP manager for the factorization duel. Holds both players' HP,
//   subtracts difficulty-weighted damage on each judged round, runs the
//   IDLE/PLAY/OVER game flow and reports the winner.
// Ports
//   CLK, RST         clock, synchronous active-high reset
//   START            begin a game (IDLE only)
//   RESTART          reload HP and return to IDLE from any state
//   EVT_VALID        HP_IN/DB_IN carry a round result this cycle
//   HP_IN            00 none, 01 self won, 10 enemy won, 11 draw
//   DB_IN            question word; difficulty in DB_IN[LVL_MSB -: LVL_W]
//   MY_HP, ENEMY_HP  current HP of each player
//   RESULT           00 none, 01 self wins, 10 enemy wins, 11 both at 0
//   GAME_OVER        high while in OVER
//   DONE             one-cycle pulse on entry to OVER
//   BUSY             high while in PLAY
module manage_hp_param #(
  parameter int HP_W     = 5,
  parameter int HP_INIT  = 10,
  parameter int DB_W     = 36,
  parameter int LVL_MSB  = 35,
  parameter int LVL_W    = 2,
  parameter int DMG_BASE = 1,
  parameter int DRAW_DMG = 0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic            RESTART,
  input  logic            EVT_VALID,
  input  logic [1:0]      HP_IN,
  input  logic [DB_W-1:0] DB_IN,
  output logic [HP_W-1:0] MY_HP,
  output logic [HP_W-1:0] ENEMY_HP,
  output logic [1:0]      RESULT,
  output logic            GAME_OVER,
  output logic            DONE,
  output logic            BUSY
);

  localparam int DW = HP_W + 1;
  localparam logic [HP_W-1:0] HP_RST = HP_W'(HP_INIT);

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_OVER} state_e;

  state_e          state_q, state_d;
  logic [HP_W-1:0] my_q, my_d;
  logic [HP_W-1:0] en_q, en_d;
  logic [1:0]      res_q, res_d;
  logic            done_q, done_d;

  logic [LVL_W-1:0] lvl;
  logic [DW-1:0]    dmg;

  assign lvl = DB_IN[LVL_MSB -: LVL_W];
  assign dmg = DW'(lvl) + DW'(DMG_BASE);

  // Subtract with a floor at zero; compared at DW bits so a damage value
  // wider than the HP register still saturates instead of wrapping.
  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                              input logic [DW-1:0]   d);
    if (d >= {1'b0, hp}) return '0;
    return hp - d[HP_W-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    my_d    = my_q;
    en_d    = en_q;
    res_d   = res_q;
    done_d  = 1'b0;
    if (RESTART) begin
      state_d = S_IDLE;
      my_d    = HP_RST;
      en_d    = HP_RST;
      res_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: if (START) state_d = S_PLAY;
        S_PLAY: begin
          if (EVT_VALID) begin
            case (HP_IN)
              2'b01: en_d = sat_sub(en_q, dmg);
              2'b10: my_d = sat_sub(my_q, dmg);
              2'b11: begin
                if (DRAW_DMG != 0) begin
                  en_d = sat_sub(en_q, dmg);
                  my_d = sat_sub(my_q, dmg);
                end
              end
              default: ;
            endcase
            // Result is judged on the next-HP values so it lands together
            // with the HP that first reads zero.
            if (my_d == '0 || en_d == '0) begin
              state_d = S_OVER;
              res_d   = {my_d == '0, en_d == '0};
              done_d  = 1'b1;
            end
          end
        end
        S_OVER: ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      my_q    <= HP_RST;
      en_q    <= HP_RST;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      my_q    <= my_d;
      en_q    <= en_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign MY_HP     = my_q;
  assign ENEMY_HP  = en_q;
  assign RESULT    = res_q;
  assign DONE      = done_q;
  assign BUSY      = (state_q == S_PLAY);
  assign GAME_OVER = (state_q == S_OVER);

endmodule

// File: tb/tb_manage_hp_param.sv
// tb_manage_hp_param
//   Drives two instances (draw ignored / draw damages) with identical
//   stimulus: directed game scenarios followed by random play, and compares
//   every output each cycle against a game-level reference model.
module tb_manage_hp_param;

  localparam int HP_INIT = 10;

  logic        CLK = 1'b0;
  logic        RST, START, RESTART, EVT_VALID;
  logic [1:0]  HP_IN;
  logic [35:0] DB_IN;

  logic [4:0] my0, en0, my1, en1;
  logic [1:0] res0, res1;
  logic       go0, dn0, bz0, go1, dn1, bz1;

  int errors = 0;
  int checks = 0;

  // Reference model: per-player HP, game phase flags, last result.
  int m_my[2], m_en[2], m_res[2];
  bit m_play[2], m_over[2], m_done[2];

  always #5 CLK = ~CLK;

  manage_hp_param #(.DRAW_DMG(0)) dut0 (
    .CLK(CLK), .RST(RST), .START(START), .RESTART(RESTART),
    .EVT_VALID(EVT_VALID), .HP_IN(HP_IN), .DB_IN(DB_IN),
    .MY_HP(my0), .ENEMY_HP(en0), .RESULT(res0),
    .GAME_OVER(go0), .DONE(dn0), .BUSY(bz0));

  manage_hp_param #(.DRAW_DMG(1)) dut1 (
    .CLK(CLK), .RST(RST), .START(START), .RESTART(RESTART),
    .EVT_VALID(EVT_VALID), .HP_IN(HP_IN), .DB_IN(DB_IN),
    .MY_HP(my1), .ENEMY_HP(en1), .RESULT(res1),
    .GAME_OVER(go1), .DONE(dn1), .BUSY(bz1));

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int hit(input int hp, input int d);
    return (d >= hp) ? 0 : hp - d;
  endfunction

  task automatic model(input int i, input bit rst, input bit restart,
                       input bit start, input bit evt, input int code,
                       input int lvl);
    int d;
    d = lvl + 1;
    m_done[i] = 0;
    if (rst || restart) begin
      m_my[i] = HP_INIT; m_en[i] = HP_INIT; m_res[i] = 0;
      m_play[i] = 0; m_over[i] = 0;
    end else if (m_play[i]) begin
      if (evt) begin
        if (code == 1 || (code == 3 && i == 1)) m_en[i] = hit(m_en[i], d);
        if (code == 2 || (code == 3 && i == 1)) m_my[i] = hit(m_my[i], d);
        if (m_my[i] == 0 || m_en[i] == 0) begin
          m_play[i] = 0; m_over[i] = 1; m_done[i] = 1;
          m_res[i] = (m_my[i] == 0 ? 2 : 0) + (m_en[i] == 0 ? 1 : 0);
        end
      end
    end else if (!m_over[i] && start) begin
      m_play[i] = 1;
    end
  endtask

  task automatic step(input bit rst, input bit restart, input bit start,
                      input bit evt, input int code, input int lvl);
    logic [1:0] l2;
    l2 = 2'(lvl);
    RST = rst; RESTART = restart; START = start; EVT_VALID = evt;
    HP_IN = 2'(code);
    DB_IN = {l2, 2'($urandom), 32'($urandom)};
    @(posedge CLK);
    model(0, rst, restart, start, evt, code, lvl);
    model(1, rst, restart, start, evt, code, lvl);
    #1;
    check("my_hp0",  32'(my0),  32'(m_my[0]));
    check("en_hp0",  32'(en0),  32'(m_en[0]));
    check("result0", 32'(res0), 32'(m_res[0]));
    check("over0",   32'(go0),  32'(m_over[0]));
    check("done0",   32'(dn0),  32'(m_done[0]));
    check("busy0",   32'(bz0),  32'(m_play[0]));
    check("my_hp1",  32'(my1),  32'(m_my[1]));
    check("en_hp1",  32'(en1),  32'(m_en[1]));
    check("result1", 32'(res1), 32'(m_res[1]));
    check("over1",   32'(go1),  32'(m_over[1]));
    check("done1",   32'(dn1),  32'(m_done[1]));
    check("busy1",   32'(bz1),  32'(m_play[1]));
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; RESTART = 1'b0; EVT_VALID = 1'b0;
    HP_IN = 2'b00; DB_IN = '0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    check("reset_my", 32'(my0), 32'(HP_INIT));
    check("reset_busy", 32'(bz0), 32'd0);

    // Five rounds at level 1 knock the enemy out.
    step(0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 1, 1, 1);
    check("s1_enemy0", 32'(en0), 32'd0);
    check("s1_result", 32'(res0), 32'd1);
    check("s1_done", 32'(dn0), 32'd1);
    // Events and START in OVER are ignored; DONE does not repeat.
    step(0, 0, 1, 1, 2, 3);
    check("s4_over_done", 32'(dn0), 32'd0);
    check("s4_over_my", 32'(my0), 32'(HP_INIT));

    // Saturation: self at 3 takes 4 damage.
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 3);          // IDLE: ignored
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 2, 3);          // START in PLAY has no effect
    step(0, 0, 0, 1, 2, 2);
    check("s2_my3", 32'(my0), 32'd3);
    step(0, 0, 0, 1, 2, 3);
    check("s2_nowrap", 32'(my0), 32'd0);
    check("s2_result", 32'(res0), 32'd2);

    // Draw with both at 2.
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 2, 3);
    step(0, 0, 0, 1, 1, 3);
    step(0, 0, 0, 1, 2, 3);
    step(0, 0, 0, 1, 1, 3);
    step(0, 0, 0, 1, 3, 1);
    check("s3_draw_res", 32'(res1), 32'd3);
    check("s3_nodraw_my", 32'(my0), 32'd2);

    // RESTART beats a same-cycle event, then START.
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 1, 0, 1, 2, 3);
    check("s5_my", 32'(my0), 32'(HP_INIT));
    step(0, 0, 1, 0, 0, 0);
    check("s5_busy", 32'(bz0), 32'd1);

    // RST mid-game.
    step(0, 0, 0, 1, 1, 3);
    step(1, 0, 0, 1, 1, 3);
    check("s6_en", 32'(en0), 32'(HP_INIT));
    step(0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0,
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
